// File: rtl/ysyx_22040895_opsel_stage.sv
// ysyx_22040895_opsel_stage
//   Operand-select stage between ID and EX. Picks operand 1 (rs1 / pc / zero)
//   and operand 2 (rs2 / imm / const 4), bypasses in-flight results from NFWD
//   later stages and registers both operands plus the forwarded rs2 (store
//   data) behind a valid/ready handshake. A load-use hazard (winning bypass
//   source still pending) holds the input off and bumps a saturating counter.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     flush_i                  kill registered op and drop current input
//     in_valid_i / in_ready_o  ID-side handshake
//     op1_sel_i, op2_sel_i     operand source selects
//     rs1_addr_i, rs2_addr_i   source register indices
//     rdata1_i, rdata2_i       register file read data
//     imm_i, pc_i              immediate and instruction PC
//     fwd_valid_i/pend_i/rd_i/data_i  bypass sources, index 0 youngest
//     out_valid_o / out_ready_i       EX-side handshake
//     opnum1_o, opnum2_o, rs2_val_o   registered operands
//     stall_cnt_o              saturating hazard-stall cycle count
module ysyx_22040895_opsel_stage #(
   parameter int XLEN    = 64,
   parameter int NFWD    = 2,
   parameter int STALL_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [1:0]             op1_sel_i,
   input  logic [1:0]             op2_sel_i,
   input  logic [4:0]             rs1_addr_i,
   input  logic [4:0]             rs2_addr_i,
   input  logic [XLEN-1:0]        rdata1_i,
   input  logic [XLEN-1:0]        rdata2_i,
   input  logic [XLEN-1:0]        imm_i,
   input  logic [XLEN-1:0]        pc_i,
   input  logic [NFWD-1:0]        fwd_valid_i,
   input  logic [NFWD-1:0]        fwd_pend_i,
   input  logic [5*NFWD-1:0]      fwd_rd_i,
   input  logic [XLEN*NFWD-1:0]   fwd_data_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [XLEN-1:0]        opnum1_o,
   output logic [XLEN-1:0]        opnum2_o,
   output logic [XLEN-1:0]        rs2_val_o,
   output logic [STALL_W-1:0]     stall_cnt_o
);

   typedef struct packed {
      logic            hit;
      logic            pend;
      logic [XLEN-1:0] data;
   } byp_t;

   // Scan oldest to youngest so the youngest match overwrites the result;
   // x0 never matches and always reads as zero.
   function automatic byp_t bypass(input logic [4:0]           addr,
                                   input logic [XLEN-1:0]      rf,
                                   input logic [NFWD-1:0]      fv,
                                   input logic [NFWD-1:0]      fp,
                                   input logic [5*NFWD-1:0]    frd,
                                   input logic [XLEN*NFWD-1:0] fdat);
      byp_t r;
      r.hit  = 1'b0;
      r.pend = 1'b0;
      r.data = rf;
      if (addr == 5'd0) begin
         r.data = '0;
      end else begin
         for (int k = NFWD - 1; k >= 0; k--) begin
            if (fv[k] && (frd[5*k +: 5] == addr)) begin
               r.hit  = 1'b1;
               r.pend = fp[k];
               r.data = fdat[XLEN*k +: XLEN];
            end
         end
      end
      return r;
   endfunction

   function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   byp_t            byp1, byp2;
   logic            hazard;
   logic            capture;
   logic [XLEN-1:0] op1_sel_val, op2_sel_val;

   logic                vld_p1;
   logic [XLEN-1:0]     op1_p1, op2_p1, rs2v_p1;
   logic [STALL_W-1:0]  stall_cnt_q;

   // ---- stage 0: bypass, hazard detect, operand select
   always_comb begin
      byp1 = bypass(rs1_addr_i, rdata1_i, fwd_valid_i, fwd_pend_i, fwd_rd_i, fwd_data_i);
      byp2 = bypass(rs2_addr_i, rdata2_i, fwd_valid_i, fwd_pend_i, fwd_rd_i, fwd_data_i);
   end

   // rs2 is always consumed as store data, so its hazard ignores op2_sel.
   assign hazard = (byp1.hit && byp1.pend && (op1_sel_i == 2'd0)) ||
                   (byp2.hit && byp2.pend);

   always_comb begin
      op1_sel_val = '0;
      case (op1_sel_i)
         2'd0:    op1_sel_val = byp1.data;
         2'd1:    op1_sel_val = pc_i;
         default: op1_sel_val = '0;
      endcase
   end

   always_comb begin
      op2_sel_val = '0;
      case (op2_sel_i)
         2'd0:    op2_sel_val = byp2.data;
         2'd1:    op2_sel_val = imm_i;
         2'd2:    op2_sel_val = {{(XLEN-3){1'b0}}, 3'b100};
         default: op2_sel_val = '0;
      endcase
   end

   assign in_ready_o = (!vld_p1 || out_ready_i) && !(in_valid_i && hazard);
   assign capture    = in_valid_i && in_ready_o && !flush_i;

   // ---- stage 1: registered operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1      <= 1'b0;
         op1_p1      <= '0;
         op2_p1      <= '0;
         rs2v_p1     <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (flush_i)
            vld_p1 <= 1'b0;
         else if (capture)
            vld_p1 <= 1'b1;
         else if (out_ready_i)
            vld_p1 <= 1'b0;

         if (capture) begin
            op1_p1  <= op1_sel_val;
            op2_p1  <= op2_sel_val;
            rs2v_p1 <= byp2.data;
         end

         if (in_valid_i && hazard && !flush_i)
            stall_cnt_q <= sat_inc(stall_cnt_q);
      end
   end

   assign out_valid_o = vld_p1;
   assign opnum1_o    = op1_p1;
   assign opnum2_o    = op2_p1;
   assign rs2_val_o   = rs2v_p1;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ysyx_22040895_opsel_stage.sv
module tb_ysyx_22040895_opsel_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready, s_in_ready;
   logic [1:0]   op1_sel, op2_sel;
   logic [4:0]   rs1_addr, rs2_addr;
   logic [63:0]  rdata1, rdata2, imm, pc;
   logic [1:0]   fwd_valid, fwd_pend;
   logic [9:0]   fwd_rd;
   logic [127:0] fwd_data;
   logic         out_valid, s_out_valid;
   logic         out_ready;
   logic [63:0]  op1, op2, rs2v, s_op1, s_op2, s_rs2v;
   logic [15:0]  stall_cnt;
   logic [1:0]   s_stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ysyx_22040895_opsel_stage dut (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .op1_sel_i(op1_sel), .op2_sel_i(op2_sel), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
      .rdata1_i(rdata1), .rdata2_i(rdata2), .imm_i(imm), .pc_i(pc),
      .fwd_valid_i(fwd_valid), .fwd_pend_i(fwd_pend), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .opnum1_o(op1), .opnum2_o(op2),
      .rs2_val_o(rs2v), .stall_cnt_o(stall_cnt)
   );

   ysyx_22040895_opsel_stage #(.STALL_W(2)) dut_s (
      .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
      .op1_sel_i(op1_sel), .op2_sel_i(op2_sel), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
      .rdata1_i(rdata1), .rdata2_i(rdata2), .imm_i(imm), .pc_i(pc),
      .fwd_valid_i(fwd_valid), .fwd_pend_i(fwd_pend), .fwd_rd_i(fwd_rd), .fwd_data_i(fwd_data),
      .out_valid_o(s_out_valid), .out_ready_i(out_ready), .opnum1_o(s_op1), .opnum2_o(s_op2),
      .rs2_val_o(s_rs2v), .stall_cnt_o(s_stall_cnt)
   );

   typedef struct {
      logic [1:0]  s1, s2;
      logic [4:0]  a1, a2;
      logic [63:0] d1, d2, im, pcv;
      logic [1:0]  fv, fp;
      logic [4:0]  r0, r1;
      logic [63:0] f0, f1;
      logic [63:0] e1, e2, er;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      flush = 0; in_valid = 0; op1_sel = 0; op2_sel = 0; rs1_addr = 0; rs2_addr = 0;
      rdata1 = 0; rdata2 = 0; imm = 0; pc = 0; fwd_valid = 0; fwd_pend = 0;
      fwd_rd = 0; fwd_data = 0;
   endtask

   task automatic apply(input vec_t v);
      op1_sel = v.s1; op2_sel = v.s2; rs1_addr = v.a1; rs2_addr = v.a2;
      rdata1 = v.d1; rdata2 = v.d2; imm = v.im; pc = v.pcv;
      fwd_valid = v.fv; fwd_pend = v.fp; fwd_rd = {v.r1, v.r0}; fwd_data = {v.f1, v.f0};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           s1 s2 a1 a2 d1     d2     imm                     pc            fv fp r0 r1 f0     f1     e1                     e2                     er
      tbl[0] = '{0, 1, 1, 2, 64'h5,  64'h9,  64'hFFFF_FFFF_FFFF_FFFD, 64'h100,     0, 0, 0, 0, 64'h0,  64'h0,  64'h5,                 64'hFFFF_FFFF_FFFF_FFFD, 64'h9};
      tbl[1] = '{0, 2, 7, 3, 64'h70, 64'h33, 64'h0,                   64'h0,       3, 0, 7, 7, 64'hAA, 64'hBB, 64'hAA,                64'h4,                   64'h33};
      tbl[2] = '{2, 0, 4, 7, 64'h44, 64'h77, 64'h0,                   64'h0,       3, 0, 5, 7, 64'hAA, 64'hBB, 64'h0,                 64'hBB,                  64'hBB};
      tbl[3] = '{0, 3, 0, 0, 64'h55, 64'h66, 64'h0,                   64'h0,       1, 1, 0, 0, 64'hFF, 64'h0,  64'h0,                 64'h0,                   64'h0};
      tbl[4] = '{1, 1, 3, 4, 64'h1,  64'h2,  64'hDEAD_BEEF_0123_4567, 64'h8000_0000, 0, 0, 0, 0, 64'h0, 64'h0,  64'h8000_0000,         64'hDEAD_BEEF_0123_4567, 64'h2};
      tbl[5] = '{3, 2, 1, 2, 64'h11, 64'h22, 64'h0,                   64'h200,     0, 0, 0, 0, 64'h0,  64'h0,  64'h0,                 64'h4,                   64'h22};
      tbl[6] = '{1, 1, 6, 3, 64'h66, 64'h33, 64'h8,                   64'h300,     2, 2, 0, 6, 64'h0,  64'hCC, 64'h300,               64'h8,                   64'h33};
      tbl[7] = '{2, 0, 1, 9, 64'h1,  64'h99, 64'h0,                   64'h0,       3, 2, 9, 9, 64'h90, 64'h91, 64'h0,                 64'h90,                  64'h90};

      clear_inputs();
      out_ready = 1;
      rst = 1;
      repeat (2) step();
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset_op1", op1, 64'd0);
      chk("reset_op2", op2, 64'd0);
      chk("reset_rs2v", rs2v, 64'd0);
      chk("reset_stall", {48'd0, stall_cnt}, 64'd0);
      rst = 0;
      step();

      for (int i = 0; i < 8; i++) begin
         apply(tbl[i]);
         in_valid = 1;
         #1;
         chk($sformatf("vec%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
         step();
         chk($sformatf("vec%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
         chk($sformatf("vec%0d_op1", i), op1, tbl[i].e1);
         chk($sformatf("vec%0d_op2", i), op2, tbl[i].e2);
         chk($sformatf("vec%0d_rs2v", i), rs2v, tbl[i].er);
      end
      chk("no_stall_yet", {48'd0, stall_cnt}, 64'd0);

      // load-use: young source pending, older non-pending match must not mask it
      clear_inputs();
      in_valid = 1; op1_sel = 0; rs1_addr = 7; rdata1 = 64'h99; op2_sel = 2'd3;
      fwd_valid = 2'b11; fwd_pend = 2'b01; fwd_rd = {5'd7, 5'd7};
      fwd_data = {64'hBB, 64'hAA};
      #1;
      chk("hz_in_ready", {63'd0, in_ready}, 64'd0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("hz_in_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
      end
      chk("hz_stall3", {48'd0, stall_cnt}, 64'd3);
      chk("hz_drained", {63'd0, out_valid}, 64'd0);
      fwd_pend = 2'b00;
      fwd_data = {64'hBB, 64'h10};
      #1;
      chk("hz_release_ready", {63'd0, in_ready}, 64'd1);
      step();
      chk("hz_cap_valid", {63'd0, out_valid}, 64'd1);
      chk("hz_cap_op1", op1, 64'h10);
      chk("hz_stall_hold", {48'd0, stall_cnt}, 64'd3);

      // backpressure hold, then flush
      out_ready = 0;
      fwd_valid = 0; rs1_addr = 1; rdata1 = 64'h22; op2_sel = 2'd2;
      #1;
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("hold_valid_c%0d", c), {63'd0, out_valid}, 64'd1);
         chk($sformatf("hold_op1_c%0d", c), op1, 64'h10);
         chk($sformatf("hold_op2_c%0d", c), op2, 64'h0);
      end
      flush = 1;
      step();
      flush = 0;
      chk("flush_kill", {63'd0, out_valid}, 64'd0);
      flush = 1;
      step();
      chk("flush_drop_input", {63'd0, out_valid}, 64'd0);
      flush = 0; in_valid = 0;
      step();
      chk("flush_stay_empty", {63'd0, out_valid}, 64'd0);

      // async reset mid-transfer
      out_ready = 1; in_valid = 1;
      step();
      chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
      chk("pre_rst_op1", op1, 64'h22);
      in_valid = 0;
      #3 rst = 1;
      #1;
      chk("arst_valid", {63'd0, out_valid}, 64'd0);
      chk("arst_op1", op1, 64'd0);
      chk("arst_op2", op2, 64'd0);
      chk("arst_stall", {48'd0, stall_cnt}, 64'd0);
      chk("arst_s_stall", {62'd0, s_stall_cnt}, 64'd0);
      #2 rst = 0;
      step();

      // saturating counter on the narrow instance
      clear_inputs();
      in_valid = 1; op1_sel = 0; rs1_addr = 7;
      fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_rd = {5'd0, 5'd7};
      repeat (3) step();
      chk("sat_s_stall3", {62'd0, s_stall_cnt}, 64'd3);
      repeat (2) step();
      chk("sat_s_stall5", {62'd0, s_stall_cnt}, 64'd3);
      chk("sat_wide_stall5", {48'd0, stall_cnt}, 64'd5);
      flush = 1;
      step();
      chk("flush_no_stall_inc", {48'd0, stall_cnt}, 64'd5);
      flush = 0;

      // rs2 pending stalls even when op2 selects imm (store data needs it)
      clear_inputs();
      in_valid = 1; op1_sel = 1; op2_sel = 1; rs2_addr = 7;
      fwd_valid = 2'b01; fwd_pend = 2'b01; fwd_rd = {5'd0, 5'd7};
      #1;
      chk("rs2_hz_ready", {63'd0, in_ready}, 64'd0);
      clear_inputs();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
